// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the 7-segment encoder and the scan-capture reader.
// Segment bit order is bit0=a ... bit6=g, active-high.
// The alternate glyphs are only accepted by the decoder when SEG7_ALT_GLYPH_EN is defined.
package seg7_pkg;

    // Segment bit positions within a 7-bit pattern
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G + 1;

    // Standard glyphs for decimal digits
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;

    // Alternate glyphs some encoders emit (6 without top bar, 7 with f, 9 without d)
    localparam logic [SEG_W-1:0] GLYPH_ALT_6 = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_ALT_7 = 7'h27;
    localparam logic [SEG_W-1:0] GLYPH_ALT_9 = 7'h67;

    // Nibble reported for any unrecognised pattern
    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational 7-segment pattern to BCD nibble decoder.
// Unknown patterns give BCD_INVALID with o_err set.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_bcd,
    output logic             o_err
);

    // Pattern lookup; default is the invalid nibble with the error flag raised
    always_comb begin
        o_bcd = BCD_INVALID;
        o_err = 1'b1;
        case (i_seg)
            GLYPH_0: begin o_bcd = 4'd0; o_err = 1'b0; end
            GLYPH_1: begin o_bcd = 4'd1; o_err = 1'b0; end
            GLYPH_2: begin o_bcd = 4'd2; o_err = 1'b0; end
            GLYPH_3: begin o_bcd = 4'd3; o_err = 1'b0; end
            GLYPH_4: begin o_bcd = 4'd4; o_err = 1'b0; end
            GLYPH_5: begin o_bcd = 4'd5; o_err = 1'b0; end
            GLYPH_6: begin o_bcd = 4'd6; o_err = 1'b0; end
            GLYPH_7: begin o_bcd = 4'd7; o_err = 1'b0; end
            GLYPH_8: begin o_bcd = 4'd8; o_err = 1'b0; end
            GLYPH_9: begin o_bcd = 4'd9; o_err = 1'b0; end
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_ALT_6: begin o_bcd = 4'd6; o_err = 1'b0; end
            GLYPH_ALT_7: begin o_bcd = 4'd7; o_err = 1'b0; end
            GLYPH_ALT_9: begin o_bcd = 4'd9; o_err = 1'b0; end
`else
            GLYPH_ALT_6,
            GLYPH_ALT_7,
            GLYPH_ALT_9: begin o_bcd = BCD_INVALID; o_err = 1'b1; end
`endif
            default: begin o_bcd = BCD_INVALID; o_err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: passive reader of a multiplexed active-high 7-segment bus.
// Each digit is debounced over STABLE_CYCLES identical samples, then stored in its
// slot; once every digit has been seen the slots are emitted as one frame on a
// valid/ready interface. A frame that cannot be handed over is dropped and flagged
// in the sticky overrun bit.
// Optional feature: SEG7_ALT_GLYPH_EN (inside seg7_glyph_decode) accepts alternate glyphs.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

    // Sampling / debounce state
    logic [IDX_W-1:0]        r_prev_idx;
    logic [SEG_W-1:0]        r_prev_seg;
    logic [7:0]              r_stab_cnt;

    // Partial frame under construction
    logic [4*NUM_DIGITS-1:0] r_slot_bcd;
    logic [NUM_DIGITS-1:0]   r_slot_err;
    logic [NUM_DIGITS-1:0]   r_seen;

    // Combinational helpers
    logic [3:0]              w_hot_cnt;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_valid;
    logic                    w_same;
    logic [7:0]              w_stab_next;
    logic                    w_latch;
    logic [NUM_DIGITS-1:0]   w_latch_mask;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_commit;
    logic                    w_can_emit;
    logic [3:0]              w_dec_bcd;
    logic                    w_dec_err;

    // Count active enables and locate the selected digit
    always_comb begin
        w_hot_cnt = 4'd0;
        w_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_en[i]) begin
                w_hot_cnt = w_hot_cnt + 4'd1;
                w_idx     = IDX_W'(i);
            end
        end
    end

    assign w_valid = (w_hot_cnt == 4'd1);
    assign w_same  = (w_idx == r_prev_idx) && (seg_in == r_prev_seg);

    // Next stability count: cleared by invalid samples, restarted by any change,
    // otherwise counting up and saturating at the threshold
    always_comb begin
        w_stab_next = 8'd0;
        if (w_valid) begin
            if (w_same) begin
                w_stab_next = (r_stab_cnt >= STAB_MAX) ? STAB_MAX : (r_stab_cnt + 8'd1);
            end else begin
                w_stab_next = 8'd1;
            end
        end
    end

    // Latch only on the sample that reaches the threshold; a held digit already
    // at the threshold stays quiet until the index or pattern changes
    assign w_latch = w_valid && (w_stab_next == STAB_MAX) &&
                     (!w_same || (r_stab_cnt != STAB_MAX));

    // Per-digit latch strobe
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_latch_mask
            assign w_latch_mask[gi] = w_latch && (w_idx == IDX_W'(gi));
        end
    endgenerate

    // A frame completes when every digit has been latched at least once
    assign w_commit    = &r_seen;
    assign w_can_emit  = !frame_valid || frame_ready;
    assign w_seen_next = (w_commit ? '0 : r_seen) | w_latch_mask;

    seg7_glyph_decode u_decode (
        .i_seg (seg_in),
        .o_bcd (w_dec_bcd),
        .o_err (w_dec_err)
    );

    // Debounce history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_idx <= '0;
            r_prev_seg <= '0;
            r_stab_cnt <= 8'd0;
        end else begin
            r_stab_cnt <= w_stab_next;
            if (w_valid) begin
                r_prev_idx <= w_idx;
                r_prev_seg <= seg_in;
            end
        end
    end

    // Slot storage and seen mask for the frame being assembled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_bcd <= '0;
            r_slot_err <= '0;
            r_seen     <= '0;
        end else begin
            r_seen <= w_seen_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_latch_mask[i]) begin
                    r_slot_bcd[4*i +: 4] <= w_dec_bcd;
                    r_slot_err[i]        <= w_dec_err;
                end
            end
        end
    end

    // Output frame register and handshake; commit copies the pre-edge slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bcd   <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_commit) begin
                if (w_can_emit) begin
                    frame_bcd   <= r_slot_bcd;
                    frame_err   <= r_slot_err;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
